bcd_to_84m2m1_serial_enc: RTL and testbench

//   Encodes a packed multi-digit BCD word into 8,4,-2,-1 weighted code, one digit
//   per clock. It is the encoder counterpart of the 84-2-1 -> BCD decoder.
//   It sits between a BCD producer and an 84-2-1 consumer.

---
 rtl/bcd_to_84m2m1_serial_enc.sv | 130 +++++++++++++
 tb/tb_bcd_to_84m2m1_serial_enc.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_84m2m1_serial_enc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bcd_to_84m2m1_serial_enc                                      |
// | Function : Serial packed-BCD to 8,4,-2,-1 encoder, one digit per clock,  |
// |            valid/ready on both sides, per-word non-BCD error flag.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bcd_to_84m2m1_serial_enc #(
  parameter int NDIGITS = 4,
  parameter int CW      = $clog2(NDIGITS + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   code_out,
  output logic                   err,
  output logic                   busy
);

  localparam int            c_width   = 4 * NDIGITS;
  localparam logic [CW-1:0] c_last    = CW'(NDIGITS - 1);

  localparam logic [1:0]    c_st_idle = 2'd0;
  localparam logic [1:0]    c_st_conv = 2'd1;
  localparam logic [1:0]    c_st_done = 2'd2;

  logic [1:0]         r_state;
  logic [c_width-1:0] r_shift;
  logic [c_width-1:0] r_acc;
  logic [c_width-1:0] r_code;
  logic               r_err_acc;
  logic               r_err;
  logic [CW-1:0]      r_cnt;

  logic [3:0]         w_digit_code;
  logic               w_digit_err;
  logic [c_width-1:0] w_acc_next;
  logic               w_err_next;

  // Full 4-bit bijection; the six non-BCD inputs take the six unused codes.
  function automatic logic [3:0] f_enc(input logic [3:0] d);
    logic [3:0] c;
    case (d)
      4'd0:    c = 4'b0000;
      4'd1:    c = 4'b0111;
      4'd2:    c = 4'b0110;
      4'd3:    c = 4'b0101;
      4'd4:    c = 4'b0100;
      4'd5:    c = 4'b1011;
      4'd6:    c = 4'b1010;
      4'd7:    c = 4'b1001;
      4'd8:    c = 4'b1000;
      4'd9:    c = 4'b1111;
      4'd10:   c = 4'b0001;
      4'd11:   c = 4'b0010;
      4'd12:   c = 4'b0011;
      4'd13:   c = 4'b1100;
      4'd14:   c = 4'b1101;
      default: c = 4'b1110;
    endcase
    return c;
  endfunction

  assign w_digit_code = f_enc(r_shift[3:0]);
  assign w_digit_err  = (r_shift[3:0] > 4'd9);
  assign w_err_next   = r_err_acc | w_digit_err;

  // New code nibble enters at the top; after NDIGITS steps digit 0 sits at the bottom.
  generate
    if (NDIGITS == 1) begin : g_acc_single
      assign w_acc_next = w_digit_code;
    end else begin : g_acc_multi
      assign w_acc_next = {w_digit_code, r_acc[c_width-1:4]};
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= c_st_idle;
      r_shift   <= '0;
      r_acc     <= '0;
      r_code    <= '0;
      r_err_acc <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_shift   <= bcd_in;
            r_acc     <= '0;
            r_err_acc <= 1'b0;
            r_cnt     <= '0;
            r_state   <= c_st_conv;
          end
        end
        c_st_conv: begin
          r_shift   <= r_shift >> 4;
          r_acc     <= w_acc_next;
          r_err_acc <= w_err_next;
          r_cnt     <= r_cnt + CW'(1);
          // Output registers load only here, so partial words never show.
          if (r_cnt == c_last) begin
            r_code  <= w_acc_next;
            r_err   <= w_err_next;
            r_state <= c_st_done;
          end
        end
        c_st_done: begin
          if (out_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign in_ready  = (r_state == c_st_idle);
  assign out_valid = (r_state == c_st_done);
  assign busy      = (r_state != c_st_idle);
  assign code_out  = r_code;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_84m2m1_serial_enc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bcd_to_84m2m1_serial_enc                                   |
// | Function : Self-checking bench for the 4-digit and 1-digit encoders.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bcd_to_84m2m1_serial_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv4, or4, ir4, ov4, er4, bz4;
  logic [15:0] bi4, co4;
  logic        iv1, or1, ir1, ov1, er1, bz1;
  logic [3:0]  bi1, co1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_to_84m2m1_serial_enc #(.NDIGITS(4)) dut4 (
    .clock(clk), .reset(rst), .in_valid(iv4), .in_ready(ir4), .bcd_in(bi4),
    .out_valid(ov4), .out_ready(or4), .code_out(co4), .err(er4), .busy(bz4)
  );

  bcd_to_84m2m1_serial_enc #(.NDIGITS(1)) dut1 (
    .clock(clk), .reset(rst), .in_valid(iv1), .in_ready(ir1), .bcd_in(bi1),
    .out_valid(ov1), .out_ready(or1), .code_out(co1), .err(er1), .busy(bz1)
  );

  // Reference: legal digits pick the code whose 8,4,-2,-1 weighted sum equals
  // the digit; non-BCD digits take the leftover codes in ascending order.
  function automatic logic [3:0] ref_digit(input logic [3:0] d);
    logic [3:0] c;
    int b3, b2, b1, b0, wt, k;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      c  = i[3:0];
      b3 = c[3]; b2 = c[2]; b1 = c[1]; b0 = c[0];
      wt = 8 * b3 + 4 * b2 - 2 * b1 - b0;
      if (d <= 4'd9) begin
        if (wt == int'(d)) return c;
      end else if (wt < 0 || wt > 9) begin
        if (k == int'(d) - 10) return c;
        k++;
      end
    end
    return 4'hx;
  endfunction

  function automatic logic [15:0] ref_word(input logic [15:0] w, input int nd);
    logic [15:0] r;
    logic [3:0]  d;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      d = w[4*i +: 4];
      r[4*i +: 4] = ref_digit(d);
    end
    return r;
  endfunction

  function automatic logic ref_err(input logic [15:0] w, input int nd);
    logic       e;
    logic [3:0] d;
    e = 1'b0;
    for (int i = 0; i < nd; i++) begin
      d = w[4*i +: 4];
      if (d > 4'd9) e = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the first falling edge after the accepting edge.
  task automatic wait_out(input bit one, input logic [15:0] exp_code, input logic exp_err,
                          input string tag);
    int lat;
    lat = 0;
    while (!(one ? ov1 : ov4) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, one ? 1 : 4);
    chk({tag, "_code"}, one ? {28'd0, co1} : {16'd0, co4}, {16'd0, exp_code});
    chk({tag, "_err"}, one ? er1 : er4, exp_err);
  endtask

  task automatic xfer(input bit one, input logic [15:0] w, input logic [15:0] exp_code,
                      input logic exp_err, input string tag);
    @(negedge clk);
    if (one) begin iv1 = 1'b1; bi1 = w[3:0]; end
    else     begin iv4 = 1'b1; bi4 = w;      end
    @(negedge clk);
    iv1 = 1'b0; iv4 = 1'b0;
    bi1 = 4'($urandom); bi4 = 16'($urandom);
    wait_out(one, exp_code, exp_err, tag);
    @(negedge clk);
    chk({tag, "_ready_after"}, one ? ir1 : ir4, 1'b1);
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] held;
    rst = 1'b1;
    iv4 = 0; or4 = 1; bi4 = '0;
    iv1 = 0; or1 = 1; bi1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", ir4, 1'b1);
    chk("rst_out_valid", ov4, 1'b0);
    chk("rst_busy", bz4, 1'b0);
    chk("rst_code", co4, 16'h0);
    chk("rst_err", er4, 1'b0);
    chk("rst_code1", co1, 4'h0);
    rst = 1'b0;

    xfer(0, 16'h1234, 16'h7654, 1'b0, "t1");
    xfer(0, 16'h9051, 16'hF0B7, 1'b0, "t2");
    for (int d = 0; d < 10; d++) begin
      w = {4'((d + 3) % 10), 4'((d + 2) % 10), 4'((d + 1) % 10), 4'(d)};
      xfer(0, w, ref_word(w, 4), 1'b0, "sweep");
    end
    xfer(0, 16'h00A0, 16'h0010, 1'b1, "t3_err");
    xfer(0, 16'h0000, 16'h0000, 1'b0, "t3_clear");

    // Backpressure with in_valid asserted and bcd_in wandering.
    or4 = 1'b0;
    @(negedge clk); iv4 = 1'b1; bi4 = 16'h2468;
    @(negedge clk); iv4 = 1'b0;
    wait_out(0, 16'h64A8, 1'b0, "t4");
    held = co4;
    for (int i = 0; i < 5; i++) begin
      iv4 = 1'b1; bi4 = 16'($urandom);
      @(negedge clk);
      chk("t4_hold_code", co4, held);
      chk("t4_hold_valid", ov4, 1'b1);
      chk("t4_hold_ready", ir4, 1'b0);
      chk("t4_hold_err", er4, 1'b0);
    end
    or4 = 1'b1; bi4 = 16'h4321;
    @(negedge clk);
    chk("t4_rel_ready", ir4, 1'b1);
    chk("t4_rel_valid", ov4, 1'b0);
    @(negedge clk); iv4 = 1'b0;
    wait_out(0, 16'h4567, 1'b0, "t4_next");
    @(negedge clk);

    // Reset two cycles into CONV.
    @(negedge clk); iv4 = 1'b1; bi4 = 16'h5678;
    @(negedge clk); iv4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_busy_pre", bz4, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_in_ready", ir4, 1'b1);
    chk("t5_out_valid", ov4, 1'b0);
    chk("t5_code", co4, 16'h0);
    chk("t5_busy", bz4, 1'b0);
    @(negedge clk); rst = 1'b0;
    xfer(0, 16'h8888, 16'h8888, 1'b0, "t5_after");

    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      xfer(0, w, ref_word(w, 4), ref_err(w, 4), "rand4");
    end

    xfer(1, 16'h0009, 16'h000F, 1'b0, "t6");
    for (int d = 0; d < 16; d++) begin
      w = 16'(d);
      xfer(1, w, ref_word(w, 1), ref_err(w, 1), "sweep1");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
